// File: rtl/layered_color_assign.sv
// Pixel colour overlay: up to NUM_WIN prioritised windows over a background,
// with double-buffered configuration and a frame-based blink phase.
module layered_color_assign #(
  parameter int COLOR_WIDTH   = 4,
  parameter int REZ_MAX_WIDTH = 11,
  parameter int NUM_WIN       = 4,
  parameter int BLINK_FRAMES  = 30
) (
  input  logic                                   Clk,
  input  logic                                   Rst,
  input  logic [3*COLOR_WIDTH-1:0]               Data,
  input  logic [REZ_MAX_WIDTH-1:0]               Count_h,
  input  logic [REZ_MAX_WIDTH-1:0]               Count_v,
  input  logic [REZ_MAX_WIDTH-1:0]               H_left_margin,
  input  logic [REZ_MAX_WIDTH-1:0]               H_right_margin,
  input  logic [REZ_MAX_WIDTH-1:0]               V_left_margin,
  input  logic [REZ_MAX_WIDTH-1:0]               V_right_margin,
  input  logic                                   Frame_start,
  input  logic                                   Cfg_we,
  input  logic [(NUM_WIN>1?$clog2(NUM_WIN):1)-1:0] Cfg_idx,
  input  logic [1:0]                             Cfg_sel,
  input  logic [2*REZ_MAX_WIDTH-1:0]             Cfg_data,
  output logic                                   Cfg_pending,
  output logic [COLOR_WIDTH-1:0]                 Red,
  output logic [COLOR_WIDTH-1:0]                 Green,
  output logic [COLOR_WIDTH-1:0]                 Blue
);

  localparam int R  = REZ_MAX_WIDTH;
  localparam int CW = 3 * COLOR_WIDTH;
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [R-1:0]  sh_hl [NUM_WIN];
  logic [R-1:0]  sh_hr [NUM_WIN];
  logic [R-1:0]  sh_vl [NUM_WIN];
  logic [R-1:0]  sh_vr [NUM_WIN];
  logic [CW-1:0] sh_col [NUM_WIN];
  logic [1:0]    sh_mode [NUM_WIN];

  logic [R-1:0]  ac_hl [NUM_WIN];
  logic [R-1:0]  ac_hr [NUM_WIN];
  logic [R-1:0]  ac_vl [NUM_WIN];
  logic [R-1:0]  ac_vr [NUM_WIN];
  logic [CW-1:0] ac_col [NUM_WIN];
  logic [1:0]    ac_mode [NUM_WIN];

  logic               wr_ok;
  logic [FW-1:0]      fcnt;
  logic               phase;
  logic               act;
  logic [NUM_WIN-1:0] rect;
  logic [NUM_WIN-1:0] on_edge;
  logic [NUM_WIN-1:0] hit;
  logic               s1_act;
  logic [NUM_WIN-1:0] s1_hit;
  logic [CW-1:0]      s1_data;
  logic [CW-1:0]      rgb_n;
  logic [CW-1:0]      rgb;

  assign wr_ok = Cfg_we && (int'(Cfg_idx) < NUM_WIN);

  // Shadow is written by the host; active copy only changes at a frame edge
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      for (int i = 0; i < NUM_WIN; i++) begin
        sh_hl[i]   <= '0;
        sh_hr[i]   <= '0;
        sh_vl[i]   <= '0;
        sh_vr[i]   <= '0;
        sh_col[i]  <= '0;
        sh_mode[i] <= 2'd3;
        ac_hl[i]   <= '0;
        ac_hr[i]   <= '0;
        ac_vl[i]   <= '0;
        ac_vr[i]   <= '0;
        ac_col[i]  <= '0;
        ac_mode[i] <= 2'd3;
      end
      Cfg_pending <= 1'b0;
    end else begin
      if (Frame_start && Cfg_pending) begin
        for (int i = 0; i < NUM_WIN; i++) begin
          ac_hl[i]   <= sh_hl[i];
          ac_hr[i]   <= sh_hr[i];
          ac_vl[i]   <= sh_vl[i];
          ac_vr[i]   <= sh_vr[i];
          ac_col[i]  <= sh_col[i];
          ac_mode[i] <= sh_mode[i];
        end
      end
      if (wr_ok) begin
        unique case (Cfg_sel)
          2'd0: begin
            sh_hl[Cfg_idx] <= Cfg_data[2*R-1:R];
            sh_hr[Cfg_idx] <= Cfg_data[R-1:0];
          end
          2'd1: begin
            sh_vl[Cfg_idx] <= Cfg_data[2*R-1:R];
            sh_vr[Cfg_idx] <= Cfg_data[R-1:0];
          end
          2'd2: sh_col[Cfg_idx]  <= Cfg_data[CW-1:0];
          2'd3: sh_mode[Cfg_idx] <= Cfg_data[1:0];
        endcase
      end
      if (wr_ok)
        Cfg_pending <= 1'b1;
      else if (Frame_start)
        Cfg_pending <= 1'b0;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      fcnt  <= '0;
      phase <= 1'b0;
    end else if (Frame_start) begin
      if (fcnt == FW'(BLINK_FRAMES - 1)) begin
        fcnt  <= '0;
        phase <= ~phase;
      end else begin
        fcnt <= fcnt + 1'b1;
      end
    end
  end

  always_comb begin
    act = (Count_h >= H_left_margin) && (Count_h <= H_right_margin) &&
          (Count_v >= V_left_margin) && (Count_v <= V_right_margin);
    rect    = '0;
    on_edge = '0;
    hit     = '0;
    for (int i = 0; i < NUM_WIN; i++) begin
      rect[i] = (Count_h >= ac_hl[i]) && (Count_h <= ac_hr[i]) &&
                (Count_v >= ac_vl[i]) && (Count_v <= ac_vr[i]);
      on_edge[i] = (Count_h == ac_hl[i]) || (Count_h == ac_hr[i]) ||
                   (Count_v == ac_vl[i]) || (Count_v == ac_vr[i]);
      unique case (ac_mode[i])
        2'd0: hit[i] = rect[i];
        2'd1: hit[i] = rect[i] && !phase;
        2'd2: hit[i] = rect[i] && on_edge[i];
        2'd3: hit[i] = 1'b0;
      endcase
    end
  end

  // Lowest index wins: scan downward so the last assignment is the winner
  always_comb begin
    rgb_n = '0;
    if (s1_act) begin
      rgb_n = s1_data;
      for (int i = NUM_WIN - 1; i >= 0; i--)
        if (s1_hit[i]) rgb_n = ac_col[i];
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      s1_act  <= 1'b0;
      s1_hit  <= '0;
      s1_data <= '0;
      rgb     <= '0;
    end else begin
      s1_act  <= act;
      s1_hit  <= hit;
      s1_data <= Data;
      rgb     <= rgb_n;
    end
  end

  assign Red   = rgb[CW-1:2*COLOR_WIDTH];
  assign Green = rgb[2*COLOR_WIDTH-1:COLOR_WIDTH];
  assign Blue  = rgb[COLOR_WIDTH-1:0];

endmodule

// File: tb/tb_layered_color_assign.sv
// Self-checking bench for layered_color_assign: directed scenarios plus
// randomized traffic against a rule-level reference model.
module tb_layered_color_assign;

  logic        Clk;
  logic        Rst;
  logic [11:0] Data;
  logic [10:0] Count_h;
  logic [10:0] Count_v;
  logic [10:0] H_left_margin;
  logic [10:0] H_right_margin;
  logic [10:0] V_left_margin;
  logic [10:0] V_right_margin;
  logic        Frame_start;
  logic        Cfg_we;
  logic [1:0]  Cfg_idx;
  logic [1:0]  Cfg_sel;
  logic [21:0] Cfg_data;
  logic        Cfg_pending;
  logic [3:0]  Red;
  logic [3:0]  Green;
  logic [3:0]  Blue;

  int checks = 0;
  int errors = 0;

  layered_color_assign #(
    .COLOR_WIDTH(4),
    .REZ_MAX_WIDTH(11),
    .NUM_WIN(4),
    .BLINK_FRAMES(2)
  ) dut (
    .Clk(Clk),
    .Rst(Rst),
    .Data(Data),
    .Count_h(Count_h),
    .Count_v(Count_v),
    .H_left_margin(H_left_margin),
    .H_right_margin(H_right_margin),
    .V_left_margin(V_left_margin),
    .V_right_margin(V_right_margin),
    .Frame_start(Frame_start),
    .Cfg_we(Cfg_we),
    .Cfg_idx(Cfg_idx),
    .Cfg_sel(Cfg_sel),
    .Cfg_data(Cfg_data),
    .Cfg_pending(Cfg_pending),
    .Red(Red),
    .Green(Green),
    .Blue(Blue)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    int hl;
    int hr;
    int vl;
    int vr;
    int col;
    int mode;
  } win_t;

  win_t sh[4];
  win_t ac[4];
  bit   pend;
  int   nfs;

  function automatic logic [31:0] rgb();
    return {20'd0, Red, Green, Blue};
  endfunction

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      sh[i] = '{0, 0, 0, 0, 0, 3};
      ac[i] = '{0, 0, 0, 0, 0, 3};
    end
    pend = 0;
    nfs  = 0;
  endtask

  task automatic model_write(int idx, int sel, logic [21:0] d);
    case (sel)
      0: begin sh[idx].hl = int'(d[21:11]); sh[idx].hr = int'(d[10:0]); end
      1: begin sh[idx].vl = int'(d[21:11]); sh[idx].vr = int'(d[10:0]); end
      2: sh[idx].col = int'(d[11:0]);
      default: sh[idx].mode = int'(d[1:0]);
    endcase
  endtask

  // Expected pixel straight from the overlay rules
  function automatic int exp_pix(int h, int v, int d);
    bit ph;
    bit inr;
    bit h_ok;
    if (h < int'(H_left_margin) || h > int'(H_right_margin) ||
        v < int'(V_left_margin) || v > int'(V_right_margin))
      return 0;
    ph = ((nfs / 2) % 2) == 1;
    for (int i = 0; i < 4; i++) begin
      inr = ac[i].hl <= h && h <= ac[i].hr && ac[i].vl <= v && v <= ac[i].vr;
      case (ac[i].mode)
        0: h_ok = inr;
        1: h_ok = inr && !ph;
        2: h_ok = inr && (h == ac[i].hl || h == ac[i].hr ||
                          v == ac[i].vl || v == ac[i].vr);
        default: h_ok = 0;
      endcase
      if (h_ok) return ac[i].col;
    end
    return d;
  endfunction

  task automatic cfg_wr(int idx, int sel, logic [21:0] d);
    Cfg_we   = 1'b1;
    Cfg_idx  = 2'(idx);
    Cfg_sel  = 2'(sel);
    Cfg_data = d;
    @(negedge Clk);
    Cfg_we = 1'b0;
    model_write(idx, sel, d);
    pend = 1;
    chk("pend_wr", {31'd0, Cfg_pending}, {31'd0, pend});
  endtask

  task automatic win_set(int idx, int hl, int hr, int vl, int vr,
                         int col, int mode);
    cfg_wr(idx, 0, {11'(hl), 11'(hr)});
    cfg_wr(idx, 1, {11'(vl), 11'(vr)});
    cfg_wr(idx, 2, 22'(col));
    cfg_wr(idx, 3, 22'(mode));
  endtask

  task automatic frame(bit wr, int idx, int sel, logic [21:0] d);
    Frame_start = 1'b1;
    if (wr) begin
      Cfg_we   = 1'b1;
      Cfg_idx  = 2'(idx);
      Cfg_sel  = 2'(sel);
      Cfg_data = d;
    end
    @(negedge Clk);
    Frame_start = 1'b0;
    Cfg_we      = 1'b0;
    if (pend) ac = sh;
    nfs++;
    if (wr) begin
      model_write(idx, sel, d);
      pend = 1;
    end else begin
      pend = 0;
    end
    chk("pend_fs", {31'd0, Cfg_pending}, {31'd0, pend});
  endtask

  task automatic px_lit(int h, int v, int exp, string tag);
    Count_h = 11'(h);
    Count_v = 11'(v);
    repeat (3) @(negedge Clk);
    chk(tag, rgb(), 32'(exp));
  endtask

  task automatic px_mod(int h, int v);
    Count_h = 11'(h);
    Count_v = 11'(v);
    repeat (3) @(negedge Clk);
    chk("rand_pix", rgb(), 32'(exp_pix(h, v, int'(Data))));
  endtask

  task automatic rand_inputs();
    Data           = 12'($urandom);
    Count_h        = 11'($urandom);
    Count_v        = 11'($urandom);
    H_left_margin  = 11'($urandom);
    H_right_margin = 11'($urandom);
    V_left_margin  = 11'($urandom);
    V_right_margin = 11'($urandom);
    Frame_start    = 1'($urandom);
    Cfg_we         = 1'($urandom);
    Cfg_idx        = 2'($urandom);
    Cfg_sel        = 2'($urandom);
    Cfg_data       = 22'($urandom);
  endtask

  initial begin
    model_reset();
    Rst = 1'b0;
    rand_inputs();
    for (int i = 0; i < 2; i++) begin
      @(negedge Clk);
      chk("rst_rgb", rgb(), 0);
      chk("rst_pend", {31'd0, Cfg_pending}, 0);
      rand_inputs();
    end
    Rst            = 1'b1;
    Frame_start    = 1'b0;
    Cfg_we         = 1'b0;
    Data           = 12'hAFA;
    Count_h        = 11'd0;
    Count_v        = 11'd0;
    H_left_margin  = 11'd112;
    H_right_margin = 11'd752;
    V_left_margin  = 11'd13;
    V_right_margin = 11'd493;
    for (int i = 0; i < 2; i++) begin
      @(negedge Clk);
      chk("rel_rgb", rgb(), 0);
      chk("rel_pend", {31'd0, Cfg_pending}, 0);
    end

    // Background, margins and exact two-cycle latency
    px_lit(0, 0, 'h000, "bg_00");
    Count_h = 11'd115;
    Count_v = 11'd15;
    @(negedge Clk);
    chk("lat_1", rgb(), 0);
    @(negedge Clk);
    chk("lat_2", rgb(), 'hAFA);
    px_lit(115, 1, 'h000, "bg_outside");
    px_lit(112, 493, 'hAFA, "bg_corner");
    px_lit(0, 0, 'h000, "bg_origin");

    // Shadowed write takes effect only at frame start
    win_set(0, 200, 300, 50, 60, 'hF00, 0);
    px_lit(250, 55, 'hAFA, "w0_shadow");
    frame(0, 0, 0, 0);
    px_lit(250, 55, 'hF00, "w0_live");

    // Priority between overlapping windows
    win_set(1, 250, 350, 50, 60, 'h0F0, 0);
    frame(0, 0, 0, 0);
    px_lit(260, 55, 'hF00, "prio_w0");
    px_lit(320, 55, 'h0F0, "prio_w1");
    cfg_wr(0, 3, 22'd3);
    frame(0, 0, 0, 0);
    px_lit(260, 55, 'h0F0, "w0_off");

    // Outline window
    win_set(2, 400, 410, 100, 110, 'h00F, 2);
    frame(0, 0, 0, 0);
    px_lit(400, 105, 'h00F, "out_left");
    px_lit(405, 110, 'h00F, "out_bot");
    px_lit(405, 105, 'hAFA, "out_inner");

    // Reset mid-pipeline drops pixels and pending configuration
    cfg_wr(1, 2, 22'h123);
    Count_h = 11'd260;
    Count_v = 11'd55;
    @(negedge Clk);
    Rst = 1'b0;
    @(negedge Clk);
    Rst = 1'b1;
    model_reset();
    chk("mid_rst_rgb", rgb(), 0);
    chk("mid_rst_pend", {31'd0, Cfg_pending}, 0);
    px_lit(260, 55, 'hAFA, "mid_rst_wins");

    // Blink: phase flips every second frame start
    win_set(3, 500, 510, 200, 210, 'h0FF, 1);
    frame(0, 0, 0, 0);
    px_lit(505, 205, 'h0FF, "blink_f1");
    frame(0, 0, 0, 0);
    px_lit(505, 205, 'hAFA, "blink_f2");
    frame(0, 0, 0, 0);
    px_lit(505, 205, 'hAFA, "blink_f3");
    frame(0, 0, 0, 0);
    px_lit(505, 205, 'h0FF, "blink_f4");
    frame(0, 0, 0, 0);
    px_lit(505, 205, 'h0FF, "blink_f5");
    frame(1, 3, 3, 22'd0);
    px_lit(505, 205, 'hAFA, "coinc_held");
    frame(0, 0, 0, 0);
    px_lit(505, 205, 'h0FF, "coinc_applied");

    // Randomized traffic over a small coordinate space
    H_left_margin  = 11'd5;
    H_right_margin = 11'd60;
    V_left_margin  = 11'd3;
    V_right_margin = 11'd58;
    for (int n = 0; n < 300; n++) begin
      int op;
      int sel;
      logic [21:0] d;
      op  = int'($urandom_range(0, 9));
      sel = int'($urandom_range(0, 3));
      case (sel)
        0, 1: d = {11'($urandom_range(0, 63)), 11'($urandom_range(0, 63))};
        2: d = 22'($urandom);
        default: d = 22'($urandom_range(0, 3));
      endcase
      if (op < 3) begin
        cfg_wr(int'($urandom_range(0, 3)), sel, d);
      end else if (op == 3) begin
        frame(1'($urandom), int'($urandom_range(0, 3)), sel, d);
      end else begin
        Data = 12'($urandom);
        px_mod(int'($urandom_range(0, 66)), int'($urandom_range(0, 66)));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
